// File: rtl/dm_arbiter_pkg.sv
// dm_arbiter_pkg: shared constants and types for the data-memory arbiter
package dm_arbiter_pkg;
   localparam int unsigned DM_WORDS_DEF = 3072;
   localparam logic [3:0] BE_NONE = 4'h0;
   localparam logic [3:0] BE_WORD = 4'hF;
   localparam logic [3:0] BE_B0 = 4'h1;
   localparam logic [3:0] BE_B1 = 4'h2;
   localparam logic [3:0] BE_B2 = 4'h4;
   localparam logic [3:0] BE_B3 = 4'h8;
   localparam logic [3:0] BE_H0 = 4'h3;
   localparam logic [3:0] BE_H1 = 4'hC;
   typedef enum logic [1:0] {
      REQ_NONE = 2'd0,
      REQ_CPU = 2'd1,
      REQ_DMA = 2'd2
   } req_id_e;
endpackage

// File: rtl/dm_arbiter_be_merge.sv
// dm_be_merge: overlays the enabled byte lanes of a new word onto an old word
module dm_be_merge (
   input logic [31:0] old_i,
   input logic [31:0] new_i,
   input logic [3:0] be_i,
   output logic [31:0] merged_o
);
   // each enabled lane takes the new byte, the rest keep the old one
   always_comb begin
      merged_o = old_i;
      for (int i = 0; i < 4; i++) merged_o[8*i+:8] = be_i[i] ? new_i[8*i+:8] : old_i[8*i+:8];
   end
endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-port data memory between the CPU M stage and a DMA port
module dm_arbiter
   import dm_arbiter_pkg::*;
#(
   parameter int unsigned DM_WORDS = DM_WORDS_DEF,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input logic clk,
   input logic reset,
   input logic cpu_req,
   input logic cpu_we,
   input logic [3:0] cpu_be,
   input logic [31:0] cpu_addr,
   input logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic cpu_stall,
   input logic dma_valid,
   output logic dma_ready,
   input logic dma_we,
   input logic [31:0] dma_addr,
   input logic [31:0] dma_wdata,
   output logic dma_rvalid,
   output logic [31:0] dma_rdata,
   output logic mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input logic [31:0] mem_rd,
   output logic err_oob
);
   logic [3:0] starve_q, starve_d;
   logic rvalid_q, rvalid_d;
   logic [31:0] rdata_q, rdata_d;
   logic err_q, err_d;
   logic dma_gnt, cpu_gnt, in_range;
   logic [31:0] merged;
   req_id_e sel;

   dm_be_merge u_merge (
      .old_i(mem_rd),
      .new_i(cpu_wdata),
      .be_i(cpu_be),
      .merged_o(merged)
   );

   // grant, memory-side muxing and next-state for the registered DMA response
   always_comb begin
      dma_gnt = dma_valid & (~cpu_req | (starve_q >= 4'(STARVE_LIMIT))) & ~reset;
      cpu_gnt = cpu_req & ~dma_gnt;
      sel = dma_gnt ? REQ_DMA : cpu_gnt ? REQ_CPU : REQ_NONE;
      mem_addr = sel == REQ_DMA ? dma_addr : sel == REQ_CPU ? cpu_addr : 32'd0;
      in_range = mem_addr[31:2] < 30'(DM_WORDS);
      mem_we = ~reset & in_range & (sel == REQ_DMA ? dma_we : sel == REQ_CPU & cpu_we & (cpu_be != BE_NONE));
      mem_wd = sel == REQ_DMA ? dma_wdata : merged;
      cpu_rdata = in_range ? mem_rd : 32'd0;
      cpu_stall = cpu_req & ~cpu_gnt;
      dma_ready = dma_gnt;
      starve_d = (dma_gnt | ~dma_valid) ? 4'd0 : starve_q == 4'd15 ? starve_q : starve_q + 4'd1;
      rvalid_d = dma_gnt & ~dma_we;
      rdata_d = rvalid_d ? cpu_rdata : rdata_q;
      err_d = err_q | (sel != REQ_NONE & ~in_range);
   end

   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         starve_q <= 4'd0;
         rvalid_q <= 1'b0;
         rdata_q <= 32'd0;
         err_q <= 1'b0;
      end else begin
         starve_q <= starve_d;
         rvalid_q <= rvalid_d;
         rdata_q <= rdata_d;
         err_q <= err_d;
      end
   end

   assign dma_rvalid = rvalid_q;
   assign dma_rdata = rdata_q;
   assign err_oob = err_q;
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port word data memory (combinational read, posedge write, 3072 words) between the pipeline M stage (CPU) and a DMA/loader port.
- Performs byte-enable stores as same-cycle read-modify-write on whole words.
- Enforces a DMA starvation bound and returns DMA read data through a registered response.
- Sits between the M-stage logic and the data memory; drives the memory's write enable, address and write data.

Parameters:
- DM_WORDS, 3072: memory depth in words; legal word index 0..DM_WORDS-1.
- STARVE_LIMIT, 4: consecutive cycles a pending DMA request may lose before it preempts the CPU; range 1..15.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset. One clock domain; reset sampled on posedge clk.
- cpu_req  input  1  M-stage memory access this cycle.
- cpu_we  input  1  1 = store, 0 = load.
- cpu_be  input  4  byte enables for stores; bit i covers wdata[8i+7:8i].
- cpu_addr  input  32  byte address.
- cpu_wdata  input  32  store data, already lane-aligned.
- cpu_rdata  output  32  combinational load word, valid in the granted cycle.
- cpu_stall  output  1  = cpu_req & ~cpu_gnt; freezes the pipeline.
- dma_valid  input  1  DMA request pending.
- dma_ready  output  1  DMA request accepted this cycle.
- dma_we  input  1  DMA store.
- dma_addr  input  32  DMA byte address; word-aligned, bits [1:0] ignored.
- dma_wdata  input  32  DMA store word (full word, all lanes).
- dma_rvalid  output  1  one-cycle pulse carrying read data.
- dma_rdata  output  32  registered read data; holds until the next read.
- mem_we  output  1  to memory write enable.
- mem_addr  output  32  to memory address.
- mem_wd  output  32  to memory write data.
- mem_rd  input  32  from memory combinational read.
- err_oob  output  1  sticky out-of-range flag.

Behaviour:
- Reset values: dma_rvalid=0, dma_rdata=0, err_oob=0, starve_cnt=0. Combinational outputs follow their equations from the first cycle after reset.
- At most one memory access per cycle. Grant is combinational from the requests and starve_cnt:
  - dma_pri = (starve_cnt >= STARVE_LIMIT).
  - dma_gnt = dma_valid & (~cpu_req | dma_pri).
  - cpu_gnt = cpu_req & ~dma_gnt.
- The DMA handshake completes when dma_valid & dma_ready. dma_ready = dma_gnt. DMA must hold its request stable until accepted.
- starve_cnt, updated on posedge clk:
  - clears to 0 when dma_gnt, or when dma_valid=0;
  - otherwise increments when dma_valid & ~dma_gnt, saturating at 15.
- Memory side:
  - mem_addr = the granted requester's address, or 0 when idle.
  - mem_we = granted & we & in_range.
- CPU store merge: mem_wd = (mem_rd & M) | (cpu_wdata & ~M), where M is the per-byte mask of ~cpu_be.
  - cpu_be=4'b0000 with cpu_we=1 is a no-op: mem_we=0.
- DMA store: mem_wd = dma_wdata.
- CPU load: cpu_rdata = in_range ? mem_rd : 0, combinational. Sub-word extraction stays in the M stage.
- DMA load: at the acceptance edge, dma_rdata <= (in_range ? mem_rd : 0) and dma_rvalid <= 1. dma_rvalid returns to 0 on the next edge unless another DMA read is accepted; back-to-back reads give a continuous dma_rvalid.
- Range rule: in_range = (addr[31:2] < DM_WORDS).
  - Out-of-range access is still granted and completes the handshake / releases the stall.
  - Writes are suppressed, reads return 0, and err_oob is set to 1 on that edge.
  - err_oob clears only on reset.
- Reset while a DMA request is pending: the request is not accepted that cycle and no mem_we is issued; starve_cnt=0 afterwards.
- Simultaneous requests to the same word: only the granted requester accesses; the loser sees the updated word when it is granted later.

Decomposition:
- Shared package: DM_WORDS default, byte-enable mask constants (BE_WORD=4'hF, BE_B0..BE_B3, BE_H0=4'h3, BE_H1=4'hC), and the requester-id constants.
- One natural sub-module: dm_be_merge, a combinational function-style block taking old word, new word and byte enables and returning the merged word.

Test Plan:
- CPU store cpu_be=4'b0010 at addr 0x10, wdata=0x0000AB00, over existing word 0x11223344 -> memory word 0x1122AB44; cpu_stall=0.
- CPU and DMA both request every cycle, STARVE_LIMIT=4 -> CPU granted 4 cycles, DMA granted in cycle 5, starve_cnt returns to 0, and the pattern repeats; cpu_stall=1 only in the DMA cycles.
- DMA read of addr 0x20 holding 0xDEADBEEF, CPU idle -> dma_ready in cycle 0; dma_rvalid=1 and dma_rdata=0xDEADBEEF in cycle 1; dma_rvalid=0 in cycle 2.
- CPU store to addr 0x3000 (word 3072) -> mem_we=0, memory unchanged, err_oob=1 from the next cycle and held until reset.
- DMA write of 0x55 to 0x40 followed immediately by a CPU load of 0x40 -> CPU reads 0x00000055.
- Assert reset for one cycle mid-contention (starve_cnt=3, dma_rvalid=1) -> after the edge starve_cnt=0, dma_rvalid=0, err_oob=0, and no write occurs in the reset cycle.
